// File: rtl/axi_mon_bw_window.sv
// rtl/axi_mon_bw_window.sv - AXI AW/AR per-region byte-count monitor over a programmable window
module axi_mon_bw_window #(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int NUM_RGN = 2,
    parameter int CNT_W   = 32,
    parameter int WIN_W   = 32
) (
    input  logic                      ref_clk,
    input  logic                      ref_rst,
    input  logic                      cfg_en,
    input  logic [WIN_W-1:0]          cfg_win_cycles,
    input  logic [NUM_RGN*ADDR_W-1:0] cfg_rgn_min,
    input  logic [NUM_RGN*ADDR_W-1:0] cfg_rgn_max,
    input  logic                      aw_valid,
    input  logic                      aw_ready,
    input  logic [ADDR_W-1:0]         aw_addr,
    input  logic [LEN_W-1:0]          aw_len,
    input  logic [2:0]                aw_size,
    input  logic                      ar_valid,
    input  logic                      ar_ready,
    input  logic [ADDR_W-1:0]         ar_addr,
    input  logic [LEN_W-1:0]          ar_len,
    input  logic [2:0]                ar_size,
    output logic                      snap_valid,
    output logic [NUM_RGN*CNT_W-1:0]  snap_wr_bytes,
    output logic [NUM_RGN*CNT_W-1:0]  snap_rd_bytes,
    output logic [CNT_W-1:0]          snap_oor_cnt,
    output logic [15:0]               snap_win_idx,
    output logic                      oor_err,
    output logic [ADDR_W-1:0]         oor_addr
);
    // Burst size needs up to LEN_W+8 bits before it is clamped to the counter width.
    localparam int BW_RAW = LEN_W + 8;
    localparam int XW     = (BW_RAW > CNT_W) ? BW_RAW : CNT_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                          state;
    logic [WIN_W-1:0]                win_cnt, win_len, win_eff;
    logic [15:0]                     win_idx;
    logic [NUM_RGN-1:0][CNT_W-1:0]   wr_acc, rd_acc, wr_nxt, rd_nxt;
    logic [CNT_W-1:0]                oor_acc, oor_nxt, aw_bytes, ar_bytes;
    logic [NUM_RGN-1:0]              aw_hit, ar_hit;
    logic                            aw_ev, ar_ev, aw_oor, ar_oor, terminal;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] burst_bytes(input logic [LEN_W-1:0] len,
                                                     input logic [2:0]       size);
        logic [XW-1:0] b;
        b = (XW'(len) + XW'(1)) << size;
        return (b > XW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : b[CNT_W-1:0];
    endfunction

    // One-hot hit; scanning downwards lets the lowest matching region win.
    function automatic logic [NUM_RGN-1:0] rgn_match(input logic [ADDR_W-1:0]         addr,
                                                     input logic [NUM_RGN*ADDR_W-1:0] mins,
                                                     input logic [NUM_RGN*ADDR_W-1:0] maxs);
        logic [NUM_RGN-1:0] hit;
        hit = '0;
        for (int i = NUM_RGN - 1; i >= 0; i--) begin
            if (mins[i*ADDR_W +: ADDR_W] < maxs[i*ADDR_W +: ADDR_W] &&
                addr >= mins[i*ADDR_W +: ADDR_W] && addr < maxs[i*ADDR_W +: ADDR_W])
                hit = NUM_RGN'(1) << i;
        end
        return hit;
    endfunction

    always_comb begin
        aw_ev    = (state == RUN) && cfg_en && aw_valid && aw_ready;
        ar_ev    = (state == RUN) && cfg_en && ar_valid && ar_ready;
        aw_hit   = rgn_match(aw_addr, cfg_rgn_min, cfg_rgn_max);
        ar_hit   = rgn_match(ar_addr, cfg_rgn_min, cfg_rgn_max);
        aw_oor   = aw_ev && (aw_hit == '0);
        ar_oor   = ar_ev && (ar_hit == '0);
        aw_bytes = burst_bytes(aw_len, aw_size);
        ar_bytes = burst_bytes(ar_len, ar_size);
        oor_nxt  = sat_add(oor_acc, CNT_W'(aw_oor) + CNT_W'(ar_oor));
        wr_nxt   = '0;
        rd_nxt   = '0;
        for (int i = 0; i < NUM_RGN; i++) begin
            wr_nxt[i] = sat_add(wr_acc[i], (aw_ev && aw_hit[i]) ? aw_bytes : '0);
            rd_nxt[i] = sat_add(rd_acc[i], (ar_ev && ar_hit[i]) ? ar_bytes : '0);
        end
        win_eff  = (cfg_win_cycles < WIN_W'(2)) ? WIN_W'(2) : cfg_win_cycles;
        terminal = (win_cnt == win_len - WIN_W'(1));
    end

    always_ff @(posedge ref_clk or posedge ref_rst) begin
        if (ref_rst) begin
            state         <= IDLE;
            win_cnt       <= '0;
            win_len       <= '0;
            win_idx       <= '0;
            wr_acc        <= '0;
            rd_acc        <= '0;
            oor_acc       <= '0;
            snap_valid    <= 1'b0;
            snap_wr_bytes <= '0;
            snap_rd_bytes <= '0;
            snap_oor_cnt  <= '0;
            snap_win_idx  <= '0;
            oor_err       <= 1'b0;
            oor_addr      <= '0;
        end else begin
            snap_valid <= 1'b0;
            oor_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        state   <= RUN;
                        win_cnt <= '0;
                        win_len <= win_eff;
                    end
                end
                RUN: begin
                    if (!cfg_en) begin
                        // Partial window is dropped; the published snapshot stays as it was.
                        state   <= IDLE;
                        win_cnt <= '0;
                        wr_acc  <= '0;
                        rd_acc  <= '0;
                        oor_acc <= '0;
                    end else begin
                        if (aw_oor || ar_oor) begin
                            oor_err  <= 1'b1;
                            oor_addr <= aw_oor ? aw_addr : ar_addr;
                        end
                        if (terminal) begin
                            snap_valid    <= 1'b1;
                            snap_wr_bytes <= wr_nxt;
                            snap_rd_bytes <= rd_nxt;
                            snap_oor_cnt  <= oor_nxt;
                            snap_win_idx  <= win_idx;
                            win_idx       <= win_idx + 16'd1;
                            win_cnt       <= '0;
                            win_len       <= win_eff;
                            wr_acc        <= '0;
                            rd_acc        <= '0;
                            oor_acc       <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            wr_acc  <= wr_nxt;
                            rd_acc  <= rd_nxt;
                            oor_acc <= oor_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
